// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type, default parameters and sizing helper for button_press_detector.
package button_pkg;
  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES = 256;
  localparam int DEF_REPEAT_CYCLES = 64;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: SYNC_STAGES-deep flop chain bringing an asynchronous bit into the clk domain.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else     s <= {s[SYNC_STAGES-2:0], d};
  assign q = s[SYNC_STAGES-1];
endmodule

// File: rtl/button_press_detector.sv
// button_press_detector: debounces a raw button into press/release pulses and a clean level.
// Define BUTTON_AUTOREPEAT_EN to emit repeated press pulses while the button is held.
module button_press_detector
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press,
  output logic release_pulse, // release is a reserved word
  output logic btn_level
);
  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, inc;
  logic sync_q, press_d, rel_d;
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(btn_in), .q(sync_q));
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_T = CW'(REPEAT_CYCLES);
  logic rep, rep_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) rep <= 1'b0;
    else     rep <= rep_d;
`endif
  // The sample that leaves IDLE/PRESSED is the first of the debounce run, so the counter
  // holds (samples seen - 1) and the run completes when inc reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    press_d = 1'b0;
    rel_d = 1'b0;
    inc = (cnt == CMAX) ? cnt : cnt + 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
    rep_d = rep;
`endif
    case (state)
      IDLE:
        if (sync_q) begin
          state_d = (DEBOUNCE_CYCLES == 1) ? PRESSED : DB_PRESS;
          press_d = (DEBOUNCE_CYCLES == 1);
          cnt_d = '0;
        end
      DB_PRESS:
        if (!sync_q) state_d = IDLE;
        else if (inc == DB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = inc;
      PRESSED: begin
`ifdef BUTTON_AUTOREPEAT_EN
        if (inc == (rep ? REP_T : HOLD_T)) begin
          press_d = 1'b1;
          cnt_d = '0;
          rep_d = 1'b1;
        end else cnt_d = inc;
        if (!sync_q) rep_d = 1'b0;
`endif
        if (!sync_q) begin
          state_d = (DEBOUNCE_CYCLES == 1) ? IDLE : DB_RELEASE;
          rel_d = (DEBOUNCE_CYCLES == 1);
          press_d = 1'b0;
          cnt_d = '0;
        end
      end
      DB_RELEASE:
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d = '0;
        end else if (inc == DB_LAST) begin
          state_d = IDLE;
          rel_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = inc;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      press <= 1'b0;
      release_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      press <= press_d;
      release_pulse <= rel_d;
      btn_level <= (state_d == PRESSED) || (state_d == DB_RELEASE);
    end
endmodule

// File: tb/tb_button_press_detector.sv
// tb_button_press_detector: directed and random stimulus checked against a sample-window reference model.
module tb_button_press_detector;
  localparam int SYNC = 2;
  localparam int DB = 4;
  localparam int HOLD = 20;
  localparam int REP = 8;
  logic clk = 1'b0, rst = 1'b1, btn_in = 1'b0;
  logic press, release_pulse, btn_level;
  int checks = 0, errors = 0, cyc = 0;
  int last_press = -1, last_rel = -1, npress = 0, nrel = 0;
  int c0, n0;
  bit sq[$];
  bit hist[$];
  bit lvl = 0, ep = 0, er = 0, s, prv = 0, flip;
  int held = 0;

  button_press_detector #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .press(press), .release_pulse(release_pulse), .btn_level(btn_level)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the coming edge using the
  // inputs held during this cycle. A level change is accepted once the last DB synchronized
  // samples all differ from the current level.
  initial forever begin
    @(negedge clk);
    chk("press", press, rst ? 0 : ep);
    chk("release", release_pulse, rst ? 0 : er);
    chk("level", btn_level, rst ? 0 : lvl);
    chk("exclusive", press & release_pulse, 0);
    if (press) begin last_press = cyc; npress++; end
    if (release_pulse) begin last_rel = cyc; nrel++; end
    if (rst) begin
      sq.delete();
      for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
      hist.delete();
      lvl = 0; ep = 0; er = 0; held = 0; prv = 0;
    end else begin
      s = sq.pop_front();
      sq.push_back(btn_in);
      hist.push_back(s);
      if (hist.size() > DB) void'(hist.pop_front());
      ep = 0; er = 0;
      flip = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] == lvl) flip = 0;
      if (flip) begin
        lvl = !lvl; ep = lvl; er = !lvl; held = 0;
      end
`ifdef BUTTON_AUTOREPEAT_EN
      else if (lvl) begin
        if (!s || !prv) held = 0;
        else begin
          held++;
          ep = (held == HOLD) || (held > HOLD && (held - HOLD) % REP == 0);
        end
      end
`endif
      prv = s;
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 btn_in = v;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    idle(3);
    #1 rst = 0;
    idle(5);
    // clean press and its release
    @(posedge clk); #1 btn_in = 1; c0 = cyc; last_press = -1;
    idle(10);
    chk("clean_lat", last_press - c0, 6);
    idle(10);
    @(posedge clk); #1 btn_in = 0; c0 = cyc; last_rel = -1; n0 = npress;
    idle(10);
    chk("release_lat", last_rel - c0, 6);
    chk("release_nopress", npress - n0, 0);
    idle(10);
    // glitch shorter than the debounce window
    n0 = npress;
    drive(1, 3);
    drive(0, 15);
    chk("glitch", npress - n0, 0);
    // bouncy press
    drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1);
    @(posedge clk); #1 btn_in = 1; c0 = cyc; n0 = npress;
    idle(12);
    chk("bouncy_cnt", npress - n0, 1);
    chk("bouncy_lat", last_press - c0, 6);
    drive(0, 15);
    // reset mid-debounce, then reset while pressed
    drive(1, 2);
    @(posedge clk); #1 rst = 1;
    idle(3);
    @(posedge clk); #1 rst = 0; c0 = cyc; last_press = -1;
    idle(12);
    chk("rst_lat", last_press - c0, 6);
    n0 = nrel;
    @(posedge clk); #1 rst = 1; btn_in = 0;
    idle(2);
    @(posedge clk); #1 rst = 0;
    idle(15);
    chk("rst_no_release", nrel - n0, 0);
    // long hold
    n0 = npress;
    drive(1, 60);
    drive(0, 20);
`ifdef BUTTON_AUTOREPEAT_EN
    chk("hold_presses", npress - n0, 6);
`else
    chk("hold_presses", npress - n0, 1);
`endif
    // random segments of bounce, holds and occasional resets
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 50)) : int'($urandom_range(1, 8)));
      if ($urandom_range(0, 30) == 0) begin
        @(posedge clk); #1 rst = 1;
        idle($urandom_range(1, 3));
        #1 rst = 0;
      end
    end
    drive(0, 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
